nano_loader: RTL

Serial program loader for the nano_riscv core. It receives a program image over a UART 8N1 line and writes it word by word into the core's instruction memory. It holds the core in reset until the last word is written, then releases it. In hardware it replaces the simulation-time memory preload: the host is the writer, this block is the receiving end that fills the memory.

---
 rtl/nano_loader.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/nano_loader.sv
// UART 8N1 program loader: receives a length-prefixed little-endian image and
// writes it into instruction memory, holding the core in reset until complete.
module nano_loader #(
  parameter int CLKS_PER_BIT = 16,
  parameter int ADDR_W       = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_core_rst,
  output logic              o_done,
  output logic              o_err
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0]   DEPTH    = 32'(2 ** ADDR_W);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {LD_LEN_LO, LD_LEN_HI, LD_DATA, LD_DONE, LD_ERR} ld_state_t;

  logic          sync1, sync2;
  rx_state_t     rx_state, rx_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    bit_idx, bit_next;
  logic [7:0]    shift, shift_next;
  logic          byte_valid, bv_next;
  logic          frame_err, ferr_next;

  ld_state_t     ld_state, ld_next;
  logic [15:0]   len;
  logic [15:0]   hdr;
  logic [1:0]    byte_idx;
  logic [ADDR_W:0] word_idx;
  logic [23:0]   word_buf;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= i_rx;
      sync2 <= sync1;
    end
  end

  // Receiver: all sampling is done on the synchronized line at mid-bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_state   <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_state   <= rx_next;
      cnt        <= cnt_next;
      bit_idx    <= bit_next;
      shift      <= shift_next;
      byte_valid <= bv_next;
      frame_err  <= ferr_next;
    end
  end

  always_comb begin
    rx_next    = rx_state;
    cnt_next   = cnt + 1'b1;
    bit_next   = bit_idx;
    shift_next = shift;
    bv_next    = 1'b0;
    ferr_next  = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        cnt_next = '0;
        if (!sync2) rx_next = RX_START;
      end
      RX_START: if (cnt == HALF_END) begin
        cnt_next = '0;
        bit_next = '0;
        rx_next  = sync2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt == BIT_END) begin
        cnt_next   = '0;
        shift_next = {sync2, shift[7:1]};
        bit_next   = bit_idx + 3'd1;
        if (bit_idx == 3'd7) rx_next = RX_STOP;
      end
      RX_STOP: if (cnt == BIT_END) begin
        cnt_next  = '0;
        rx_next   = RX_IDLE;
        bv_next   = sync2;
        ferr_next = !sync2;
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  assign hdr = {shift, len[7:0]};

  always_ff @(posedge i_clk) begin
    if (i_rst) ld_state <= LD_LEN_LO;
    else       ld_state <= ld_next;
  end

  // Completion is judged on the strobe cycle so done trails the last write.
  always_comb begin
    ld_next = ld_state;
    unique case (ld_state)
      LD_LEN_LO:
        if (frame_err)       ld_next = LD_ERR;
        else if (byte_valid) ld_next = LD_LEN_HI;
      LD_LEN_HI:
        if (frame_err) ld_next = LD_ERR;
        else if (byte_valid) begin
          if (hdr == 16'd0)              ld_next = LD_DONE;
          else if (32'(hdr) > DEPTH)     ld_next = LD_ERR;
          else                           ld_next = LD_DATA;
        end
      LD_DATA:
        if (frame_err) ld_next = LD_ERR;
        else if (o_mem_we && 32'(word_idx) == 32'(len)) ld_next = LD_DONE;
      LD_DONE: ld_next = LD_DONE;
      LD_ERR:  ld_next = LD_ERR;
      default: ld_next = LD_ERR;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      len         <= '0;
      byte_idx    <= '0;
      word_idx    <= '0;
      word_buf    <= '0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
    end else begin
      o_mem_we <= 1'b0;
      if (byte_valid && !frame_err) begin
        unique case (ld_state)
          LD_LEN_LO: len[7:0]  <= shift;
          LD_LEN_HI: len[15:8] <= shift;
          LD_DATA: begin
            byte_idx <= byte_idx + 2'd1;
            unique case (byte_idx)
              2'd0: word_buf[7:0]   <= shift;
              2'd1: word_buf[15:8]  <= shift;
              2'd2: word_buf[23:16] <= shift;
              2'd3: begin
                o_mem_we    <= 1'b1;
                o_mem_addr  <= word_idx[ADDR_W-1:0];
                o_mem_wdata <= {shift, word_buf};
                word_idx    <= word_idx + 1'b1;
              end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign o_done     = (ld_state == LD_DONE);
  assign o_err      = (ld_state == LD_ERR);
  assign o_core_rst = (ld_state != LD_DONE);

endmodule
